// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: receive-side timing monitor for a 640x480@60 VGA link.
// It rebuilds line and frame timing from hsync, vsync and RGB565. Each frame is
// checked against the nominal format. Lock is declared after LOCK_FRAMES clean
// frames. While locked, the block outputs coordinates and data for each active pixel.
//
// Ports:
//   vga_clk      in   pixel clock
//   sys_rst_n    in   asynchronous active-low reset
//   hsync_in     in   line sync (active high at line start)
//   vsync_in     in   frame sync (active high for the first lines of a frame)
//   rgb_in       in   16-bit pixel data
//   pix_x/pix_y  out  active column/row, 10'h3ff when not an active locked pixel
//   pix_valid    out  pix_x/pix_y/pix_data describe an active pixel
//   pix_data     out  captured pixel, 0 when pix_valid is low
//   frame_start  out  one-cycle pulse per detected frame start
//   locked       out  monitor is in the LOCKED state
//   h_total_meas out  clocks in the last complete line
//   v_total_meas out  lines in the last complete frame
//   err_cnt      out  saturating count of lock losses
//   frame_crc    out  CRC-16-CCITT of the last fully locked frame
//   crc_valid    out  one-cycle pulse when frame_crc updates
//
// Optional feature: define VGA_RX_CRC_EN to build the frame CRC. Without the
// macro, frame_crc is tied to 0 and crc_valid is tied to 0.
module vga_rx_monitor #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_START     = 144,
    parameter int unsigned H_VALID     = 640,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_START     = 35,
    parameter int unsigned V_VALID     = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [15:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        frame_start,
    output logic        locked,
    output logic [9:0]  h_total_meas,
    output logic [9:0]  v_total_meas,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);

    localparam int unsigned CW = 10;
    localparam int unsigned DW = 16;
    localparam int unsigned GW = 3;
    localparam int unsigned EW = 8;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [EW-1:0] ERR_MAX = {EW{1'b1}};
    localparam logic [CW-1:0] H_BEG   = CW'(H_START);
    localparam logic [CW-1:0] H_END   = CW'(H_START + H_VALID);
    localparam logic [CW-1:0] V_BEG   = CW'(V_START);
    localparam logic [CW-1:0] V_END   = CW'(V_START + V_VALID);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SW    = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SW    = CW'(V_SYNC);
    localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t         state;
    logic           hs_r;
    logic           hs_d;
    logic           vs_ls;
    logic [DW-1:0]  rgb_r;
    logic [CW-1:0]  h_cnt;
    logic [CW-1:0]  v_cnt;
    logic [CW-1:0]  vs_lines;
    logic           line_err;
    logic [GW-1:0]  good_cnt;

    logic           line_start;
    logic           fs_ev;
    logic           hs_fall;
    logic           vs_fall;
    logic           err_now;
    logic           frame_good;
    logic           enter_lock;
    logic           drop_lock;
    logic           in_win;

    // Timing events and error detection.
    // Line start is taken from the raw input edge. Because of this, h_cnt==k in the same
    // cycle as rgb_r holds column k.
    always_comb begin
        line_start = hsync_in & ~hs_r;
        fs_ev      = line_start & vsync_in & ~vs_ls;
        hs_fall    = ~hs_r & hs_d;
        vs_fall    = line_start & ~vsync_in & vs_ls;
        err_now    = line_err
                   | (line_start & (h_cnt != H_LAST))
                   | (hs_fall & (h_cnt != H_SW))
                   | (vs_fall & (vs_lines != V_SW))
                   | ((h_cnt == CNT_MAX) & ~line_start);
        frame_good = (v_cnt == V_LAST) & ~err_now;
        enter_lock = (state == ST_SEARCH) & fs_ev & frame_good
                   & ((good_cnt + GW'(1)) == LOCK_N);
        drop_lock  = (state == ST_LOCKED)
                   & ((fs_ev & ~frame_good) | (v_cnt == CNT_MAX));
        in_win     = (state == ST_LOCKED)
                   & (h_cnt >= H_BEG) & (h_cnt < H_END)
                   & (v_cnt >= V_BEG) & (v_cnt < V_END);
    end

    // Input capture, h/v counters, measurements and sticky frame error.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_r         <= 1'b0;
            hs_d         <= 1'b0;
            vs_ls        <= 1'b0;
            rgb_r        <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            vs_lines     <= '0;
            line_err     <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
        end else begin
            hs_r  <= hsync_in;
            hs_d  <= hs_r;
            rgb_r <= rgb_in;

            if (line_start) begin
                vs_ls        <= vsync_in;
                h_cnt        <= '0;
                h_total_meas <= h_cnt + CW'(1);
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + CW'(1);
            end

            if (fs_ev) begin
                // The finished frame has already been judged, so the new frame starts with no error.
                v_cnt        <= '0;
                v_total_meas <= v_cnt + CW'(1);
                vs_lines     <= CW'(1);
                line_err     <= 1'b0;
            end else begin
                if (line_start) begin
                    if (v_cnt != CNT_MAX) begin
                        v_cnt <= v_cnt + CW'(1);
                    end
                    if (vsync_in && (vs_lines != CNT_MAX)) begin
                        vs_lines <= vs_lines + CW'(1);
                    end
                end
                line_err <= err_now;
            end
        end
    end

    // Lock state machine: IDLE -> SEARCH -> LOCKED, and back to SEARCH on a bad frame.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            locked      <= 1'b0;
            err_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= fs_ev;
            case (state)
                ST_IDLE: begin
                    if (fs_ev) begin
                        state <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (enter_lock) begin
                        state    <= ST_LOCKED;
                        locked   <= 1'b1;
                        good_cnt <= '0;
                    end else if (fs_ev) begin
                        good_cnt <= frame_good ? (good_cnt + GW'(1)) : '0;
                    end
                end
                ST_LOCKED: begin
                    if (drop_lock) begin
                        state    <= ST_SEARCH;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + EW'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Pixel output stage: adds the second register of latency.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_valid <= 1'b0;
            pix_x     <= CNT_MAX;
            pix_y     <= CNT_MAX;
            pix_data  <= '0;
        end else if (in_win) begin
            pix_valid <= 1'b1;
            pix_x     <= h_cnt - H_BEG;
            pix_y     <= v_cnt - V_BEG;
            pix_data  <= rgb_r;
        end else begin
            pix_valid <= 1'b0;
            pix_x     <= CNT_MAX;
            pix_y     <= CNT_MAX;
            pix_data  <= '0;
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [DW-1:0] crc;
    logic          crc_run;

    // CRC-16-CCITT (poly 0x1021). One word is processed per call, MSB first.
    function automatic logic [DW-1:0] crc_step(input logic [DW-1:0] c,
                                               input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic          fb;
        r = c;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = r[DW-1] ^ d[i];
            r  = {r[DW-2:0], 1'b0};
            if (fb) begin
                r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    // crc_run marks a frame that has been locked since its frame start.
    // The CRC is published only for such frames.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            crc       <= 16'hFFFF;
            crc_run   <= 1'b0;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (fs_ev) begin
                if (crc_run) begin
                    frame_crc <= crc;
                    crc_valid <= 1'b1;
                end
                crc     <= 16'hFFFF;
                crc_run <= enter_lock | ((state == ST_LOCKED) & ~drop_lock);
            end else begin
                if (drop_lock) begin
                    crc_run <= 1'b0;
                end
                if (pix_valid) begin
                    crc <= crc_step(crc, pix_data);
                end
            end
        end
    end
`else
    assign frame_crc = '0;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Testbench for vga_rx_monitor. It uses a reduced video format so that many frames fit in a short run.
// A table of frames is driven through the DUT. Each row gives the frame's defects and the state
// expected just after that frame starts. A scoreboard checks every output pixel, including the
// data and the 2-clock latency.
module tb_vga_rx_monitor;

    localparam int H_SYNC  = 4;
    localparam int H_T     = 24;
    localparam int H_START = 8;
    localparam int H_VALID = 12;
    localparam int V_SYNC  = 2;
    localparam int V_T     = 14;
    localparam int V_START = 4;
    localparam int V_VALID = 6;
    localparam int LOCK_FRAMES = 2;

    localparam int MODE_RED  = 0;
    localparam int MODE_IDX  = 1;
    localparam int MODE_ZERO = 2;

    logic        vga_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        hsync_in  = 1'b0;
    logic        vsync_in  = 1'b0;
    logic [15:0] rgb_in    = 16'h0;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        frame_start;
    logic        locked;
    logic [9:0]  h_total_meas;
    logic [9:0]  v_total_meas;
    logic [7:0]  err_cnt;
    logic [15:0] frame_crc;
    logic        crc_valid;

    vga_rx_monitor #(
        .H_SYNC(H_SYNC), .H_TOTAL(H_T), .H_START(H_START), .H_VALID(H_VALID),
        .V_SYNC(V_SYNC), .V_TOTAL(V_T), .V_START(V_START), .V_VALID(V_VALID),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .pix_data(pix_data), .frame_start(frame_start),
        .locked(locked), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
        .err_cnt(err_cnt), .frame_crc(frame_crc), .crc_valid(crc_valid)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Independent bit-serial CRC-16-CCITT reference (init 0xFFFF, MSB first).
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 16; i++) begin
            if (r[15] ^ d[15-i]) r = (r << 1) ^ 16'h1021;
            else                 r = r << 1;
        end
        return r;
    endfunction

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
        int          due;
    } pix_t;

    pix_t sb[$];
    pix_t mon_e;
    logic mon_en = 1'b0;

    // Scoreboard side. Every valid pixel must match the head entry on its due cycle.
    // Every idle cycle must show the idle output values.
    always @(negedge vga_clk) begin
        if (mon_en) begin
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pix_valid", 64'(pix_valid), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("pix_xyd", 64'({pix_x, pix_y, pix_data}), 64'({mon_e.x, mon_e.y, mon_e.d}));
                    chk("pix_latency", 64'(cyc), 64'(mon_e.due));
                end
            end else begin
                chk("idle_pix_outputs", 64'({pix_x, pix_y, pix_data}), 64'({10'h3ff, 10'h3ff, 16'h0}));
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    chk("missing_pix_valid", 64'(pix_valid), 64'(1));
                    sb.delete(0);
                end
            end
        end
    end

    // Behavioural lock model (0 idle, 1 search, 2 locked).
    int          m_state   = 0;
    int          m_good    = 0;
    logic        m_prev_ok = 1'b0;
    logic        m_crc_run = 1'b0;
    logic [15:0] m_crc     = 16'hFFFF;
    logic        m_pulse   = 1'b0;
    logic [15:0] m_crc_exp = 16'h0;

    task automatic model_frame_start(input logic this_ok);
        m_pulse   = m_crc_run;
        m_crc_exp = m_crc;
        case (m_state)
            0: m_state = 1;
            1: begin
                if (m_prev_ok) begin
                    m_good++;
                    if (m_good == LOCK_FRAMES) begin
                        m_state = 2;
                        m_good  = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end
            default: begin
                if (!m_prev_ok) begin
                    m_state = 1;
                    m_good  = 0;
                end
            end
        endcase
        m_crc_run = (m_state == 2);
        m_crc     = 16'hFFFF;
        m_prev_ok = this_ok;
    endtask

    typedef struct {
        int stretch_row;  // line made one clock longer (-1: none)
        int hold_row;     // line with hsync held low for 1100 extra clocks (-1: none)
        int mode;         // active-pixel data pattern
        int rst_row;      // reset pulse at column 10 of this row (-1: none)
        int exp_locked;   // expected just after this frame's start
        int exp_err;
        int exp_h;        // -1: not checked
        int exp_v;
    } vec_t;

    function automatic logic [15:0] pix_val(input int mode, input int x, input int y);
        if (mode == MODE_RED) return 16'hF800;
        if (mode == MODE_IDX) return 16'(y * H_VALID + x);
        return 16'h0;
    endfunction

    task automatic send_frame(input vec_t v);
        int   len;
        logic act;
        for (int r = 0; r < V_T; r++) begin
            len = H_T + ((r == v.stretch_row) ? 1 : 0) + ((r == v.hold_row) ? 1100 : 0);
            for (int c = 0; c < len; c++) begin
                @(posedge vga_clk); #1;
                if (!sys_rst_n) sys_rst_n = 1'b1;
                act = (c >= H_START) && (c < H_START + H_VALID) &&
                      (r >= V_START) && (r < V_START + V_VALID);
                hsync_in = (c < H_SYNC);
                vsync_in = (r < V_SYNC);
                rgb_in   = act ? pix_val(v.mode, c - H_START, r - V_START) : 16'($urandom);
                if (r == 0 && c == 0)
                    model_frame_start((v.stretch_row < 0) && (v.hold_row < 0));
                if (act && m_state == 2) begin
                    sb.push_back('{x: 10'(c - H_START), y: 10'(r - V_START), d: rgb_in, due: cyc + 2});
                    m_crc = crc_ref(m_crc, rgb_in);
                end
                if (r == 0 && c == 1) begin
                    chk("frame_start_pulse", 64'(frame_start), 64'(1));
                    chk("locked", 64'(locked), 64'(v.exp_locked));
                    chk("err_cnt", 64'(err_cnt), 64'(v.exp_err));
                    if (v.exp_h >= 0) chk("h_total_meas", 64'(h_total_meas), 64'(v.exp_h));
                    if (v.exp_v >= 0) chk("v_total_meas", 64'(v_total_meas), 64'(v.exp_v));
`ifdef VGA_RX_CRC_EN
                    chk("crc_valid", 64'(crc_valid), 64'(m_pulse));
                    if (m_pulse) chk("frame_crc", 64'(frame_crc), 64'(m_crc_exp));
`else
                    chk("crc_valid_off", 64'(crc_valid), 64'(0));
                    chk("frame_crc_off", 64'(frame_crc), 64'(0));
`endif
                end
                if (r == 0 && c == 2) begin
                    chk("frame_start_one_cycle", 64'(frame_start), 64'(0));
                    chk("crc_valid_one_cycle", 64'(crc_valid), 64'(0));
                end
                if (r == v.hold_row && c == H_T + 1050)
                    chk("h_cnt_saturated", 64'(dut.h_cnt), 64'(1023));
                if (r == v.rst_row && c == 10) begin
                    sys_rst_n = 1'b0;
                    #1;
                    chk("rst_pix_and_lock", 64'({pix_x, pix_y, pix_valid, pix_data, frame_start, locked}),
                        64'({10'h3ff, 10'h3ff, 1'b0, 16'h0, 1'b0, 1'b0}));
                    chk("rst_meas_and_crc", 64'({h_total_meas, v_total_meas, err_cnt, frame_crc, crc_valid}),
                        64'(0));
                    sb.delete();
                    m_state   = 0;
                    m_good    = 0;
                    m_crc_run = 1'b0;
                    m_crc     = 16'hFFFF;
                end
            end
        end
    endtask

    vec_t tbl[16];

    initial begin
        //            stretch hold mode       rst  lock err  h   v
        tbl[0]  = '{-1, -1, MODE_RED,  -1, 0, 0, -1, -1};
        tbl[1]  = '{-1, -1, MODE_RED,  -1, 0, 0, 24, 14};
        tbl[2]  = '{-1, -1, MODE_IDX,  -1, 1, 0, 24, 14};  // lock at 3rd frame start
        tbl[3]  = '{ 5, -1, MODE_IDX,  -1, 1, 0, 24, 14};  // line of 25 clocks
        tbl[4]  = '{-1, -1, MODE_IDX,  -1, 0, 1, 24, 14};
        tbl[5]  = '{-1, -1, MODE_IDX,  -1, 0, 1, 24, 14};
        tbl[6]  = '{-1, -1, MODE_IDX,  -1, 1, 1, 24, 14};  // regained after 2 clean frames
        tbl[7]  = '{-1,  7, MODE_IDX,  -1, 1, 1, 24, 14};  // hsync low 1100 clocks
        tbl[8]  = '{-1, -1, MODE_IDX,  -1, 0, 2, 24, 14};
        tbl[9]  = '{-1, -1, MODE_ZERO, -1, 0, 2, 24, 14};
        tbl[10] = '{-1, -1, MODE_ZERO, -1, 1, 2, 24, 14};
        tbl[11] = '{-1, -1, MODE_IDX,   5, 1, 2, 24, 14};  // zero-frame CRC, then reset mid-line
        tbl[12] = '{-1, -1, MODE_IDX,  -1, 0, 0, 24,  9};  // 8 line starts counted since reset
        tbl[13] = '{-1, -1, MODE_IDX,  -1, 0, 0, 24, 14};
        tbl[14] = '{-1, -1, MODE_IDX,  -1, 1, 0, 24, 14};
        tbl[15] = '{-1, -1, MODE_RED,  -1, 1, 0, 24, 14};

        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset_pix", 64'({pix_x, pix_y, pix_valid, pix_data}), 64'({10'h3ff, 10'h3ff, 1'b0, 16'h0}));
        chk("reset_status", 64'({frame_start, locked, err_cnt, h_total_meas, v_total_meas}), 64'(0));
        chk("reset_crc", 64'({frame_crc, crc_valid}), 64'(0));
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;

        for (int i = 0; i < 16; i++) send_frame(tbl[i]);

        repeat (30) @(posedge vga_clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        chk("final_locked", 64'(locked), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
